// File: rtl/wf_class_arbiter_pkg.sv
// Shared defaults and helpers for the per-class wavefront arbiter.
package wf_class_arbiter_pkg;

  localparam int DEF_NUM_WF       = 40;
  localparam int DEF_WF_ID_LENGTH = 6;

  // Functional-unit classes, one arbiter instance per class.
  typedef enum logic [1:0] {
    FU_SIMD = 2'd0,
    FU_SIMF = 2'd1,
    FU_LSU  = 2'd2,
    FU_SALU = 2'd3
  } fu_class_e;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/wf_class_arbiter_rr_prio_encoder.sv
// Round-robin priority encoder: lowest set request at or after the start index, with wrap.
module rr_prio_encoder #(
  parameter int NUM_WF       = 40,
  parameter int WF_ID_LENGTH = 6
) (
  input  logic [NUM_WF-1:0]       i_req,
  input  logic [WF_ID_LENGTH-1:0] i_start,
  output logic                    o_found,
  output logic [WF_ID_LENGTH-1:0] o_idx
);

  logic [2*NUM_WF-1:0]   w_dbl;
  logic [NUM_WF-1:0]     w_rot;
  logic [WF_ID_LENGTH:0] w_off;
  logic [WF_ID_LENGTH:0] w_sum;

  // Rotating the doubled mask puts the start index at bit 0.
  assign w_dbl = {i_req, i_req};
  assign w_rot = NUM_WF'(w_dbl >> i_start);

  always_comb begin
    w_off   = '0;
    o_found = 1'b0;
    for (int i = NUM_WF - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_off   = (WF_ID_LENGTH+1)'(i);
        o_found = 1'b1;
      end
    end
  end

  assign w_sum = {1'b0, i_start} + w_off;

  always_comb begin
    o_idx = '0;
    if (o_found) begin
      if (w_sum >= (WF_ID_LENGTH+1)'(NUM_WF))
        o_idx = WF_ID_LENGTH'(w_sum - (WF_ID_LENGTH+1)'(NUM_WF));
      else
        o_idx = w_sum[WF_ID_LENGTH-1:0];
    end
  end

endmodule

// File: rtl/wf_class_arbiter.sv
// Per-class wavefront picker: round-robin candidate, pointer and one-cycle issue shadow.
module wf_class_arbiter
  import wf_class_arbiter_pkg::*;
#(
  parameter int NUM_WF       = DEF_NUM_WF,
  parameter int WF_ID_LENGTH = DEF_WF_ID_LENGTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_WF-1:0]       wf_ready,
  input  logic                    class_issued,
  input  logic [WF_ID_LENGTH-1:0] issued_wfid,
  output logic                    wf_valid,
  output logic [WF_ID_LENGTH-1:0] wf_chosen,
  output logic [NUM_WF-1:0]       wf_issued_shadow
);

  logic [WF_ID_LENGTH-1:0] r_last_ptr;
  logic [NUM_WF-1:0]       r_shadow;

  logic [NUM_WF-1:0]       w_elig;
  logic [WF_ID_LENGTH-1:0] w_start;
  logic                    w_found;
  logic [WF_ID_LENGTH-1:0] w_idx;
  logic                    w_issue_ok;

  // Scoreboard clears wf_ready a cycle late, so mask out last cycle's issue.
  assign w_elig  = wf_ready & ~r_shadow;
  assign w_start = WF_ID_LENGTH'(rr_next(int'(r_last_ptr), NUM_WF));

  rr_prio_encoder #(
    .NUM_WF       (NUM_WF),
    .WF_ID_LENGTH (WF_ID_LENGTH)
  ) u_enc (
    .i_req   (w_elig),
    .i_start (w_start),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign wf_valid         = rst & w_found;
  assign wf_chosen        = rst ? w_idx : '0;
  assign wf_issued_shadow = r_shadow;

  // An out-of-range wfid can never equal the candidate, so it is dropped here too.
  assign w_issue_ok = class_issued & wf_valid & (issued_wfid == wf_chosen);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_ptr <= WF_ID_LENGTH'(NUM_WF - 1);
      r_shadow   <= '0;
    end else begin
      if (w_issue_ok) begin
        r_last_ptr <= issued_wfid;
        r_shadow   <= NUM_WF'(1) << issued_wfid;
      end else begin
        r_shadow   <= '0;
      end
    end
  end

  a_issue_protocol: assert property (@(posedge clk) disable iff (!rst)
    class_issued |-> (wf_valid && (issued_wfid == wf_chosen)))
    else $warning("wf_class_arbiter: issued_wfid %0d differs from candidate %0d (valid=%0b)",
                  issued_wfid, wf_chosen, wf_valid);

endmodule

// File: tb/tb_wf_class_arbiter.sv
// Scoreboard bench for wf_class_arbiter: directed steps push expectations, a monitor compares.
module tb_wf_class_arbiter;

  localparam int NW = 40;
  localparam int IW = 6;

  logic          clk;
  logic          rst;
  logic [NW-1:0] wf_ready;
  logic          class_issued;
  logic [IW-1:0] issued_wfid;
  logic          wf_valid;
  logic [IW-1:0] wf_chosen;
  logic [NW-1:0] wf_issued_shadow;

  wf_class_arbiter #(.NUM_WF(NW), .WF_ID_LENGTH(IW)) dut (
    .clk              (clk),
    .rst              (rst),
    .wf_ready         (wf_ready),
    .class_issued     (class_issued),
    .issued_wfid      (issued_wfid),
    .wf_valid         (wf_valid),
    .wf_chosen        (wf_chosen),
    .wf_issued_shadow (wf_issued_shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          v;
    logic [IW-1:0] c;
    logic [NW-1:0] sh;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  event ev_chk;

  function automatic logic [NW-1:0] b(input int i);
    logic [NW-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Monitor: compares queued expectations at each falling edge or on demand.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or ev_chk);
      while (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (wf_valid !== e.v) begin
          bad++;
          $display("FAIL %s valid: got %0b want %0b", e.name, wf_valid, e.v);
        end
        total++;
        if (wf_chosen !== e.c) begin
          bad++;
          $display("FAIL %s chosen: got %0d want %0d", e.name, wf_chosen, e.c);
        end
        total++;
        if (wf_issued_shadow !== e.sh) begin
          bad++;
          $display("FAIL %s shadow: got %h want %h", e.name, wf_issued_shadow, e.sh);
        end
      end
    end
  end

  // Called at posedge+1: drive inputs, queue expectation, advance one cycle.
  task automatic step(input string nm, input logic [NW-1:0] rdy, input logic ci,
                      input logic [IW-1:0] iw, input logic ev, input logic [IW-1:0] ec,
                      input logic [NW-1:0] es);
    exp_t e;
    wf_ready     = rdy;
    class_issued = ci;
    issued_wfid  = iw;
    e.name = nm; e.v = ev; e.c = ec; e.sh = es;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input logic ev, input logic [IW-1:0] ec,
                           input logic [NW-1:0] es);
    exp_t e;
    e.name = nm; e.v = ev; e.c = ec; e.sh = es;
    q.push_back(e);
    #1;
    -> ev_chk;
    #1;
  endtask

  initial begin
    logic [NW-1:0] r3739;
    r3739        = b(3) | b(7) | b(39);
    rst          = 1'b0;
    wf_ready     = r3739;
    class_issued = 1'b0;
    issued_wfid  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_now("rst_hold", 1'b0, 6'd0, '0);

    @(posedge clk);
    #1;
    rst = 1'b1;
    step("cold",     r3739, 1'b0, 6'd0,  1'b1, 6'd3,  '0);
    step("rot_3",    r3739, 1'b1, 6'd3,  1'b1, 6'd3,  '0);
    step("rot_7",    r3739, 1'b1, 6'd7,  1'b1, 6'd7,  b(3));
    step("rot_39",   r3739, 1'b1, 6'd39, 1'b1, 6'd39, b(7));
    step("rot_3b",   r3739, 1'b1, 6'd3,  1'b1, 6'd3,  b(39));
    step("idle_7",   r3739, 1'b0, 6'd0,  1'b1, 6'd7,  b(3));
    step("iss_7",    r3739, 1'b1, 6'd7,  1'b1, 6'd7,  '0);
    step("iss_39",   r3739, 1'b1, 6'd39, 1'b1, 6'd39, b(7));
    step("only39",   b(39), 1'b0, 6'd0,  1'b0, 6'd0,  b(39));
    step("wrap_0",   b(0) | b(39), 1'b0, 6'd0, 1'b1, 6'd0, '0);
    step("single39", b(39), 1'b0, 6'd0,  1'b1, 6'd39, '0);
    step("empty",    '0,    1'b0, 6'd0,  1'b0, 6'd0,  '0);
    for (int k = 0; k < 4; k++)
      step("hold_5", b(5) | b(6), 1'b0, 6'd0, 1'b1, 6'd5, '0);
    step("proto_err",  b(5) | b(6), 1'b1, 6'd6, 1'b1, 6'd5, '0);
    step("after_err",  b(5) | b(6), 1'b0, 6'd0, 1'b1, 6'd5, '0);
    step("iss_5",      b(5) | b(6), 1'b1, 6'd5, 1'b1, 6'd5, '0);
    step("iss_6",      b(5) | b(6), 1'b1, 6'd6, 1'b1, 6'd6, b(5));
    step("post_6",     b(5) | b(6), 1'b0, 6'd0, 1'b1, 6'd5, b(6));
    step("oor_id",     b(5) | b(6), 1'b1, 6'd45, 1'b1, 6'd5, '0);
    step("after_oor",  b(5) | b(6), 1'b0, 6'd0, 1'b1, 6'd5, '0);
    step("pre_rst_7",  b(3) | b(7), 1'b1, 6'd7, 1'b1, 6'd7, '0);

    wf_ready     = b(3) | b(7);
    class_issued = 1'b0;
    check_now("shadow_7", 1'b1, 6'd3, b(7));
    rst = 1'b0;
    check_now("mid_rst", 1'b0, 6'd0, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step("cold2_0",  b(0) | b(8), 1'b0, 6'd0, 1'b1, 6'd0, '0);
    step("cold2_i0", b(0) | b(8), 1'b1, 6'd0, 1'b1, 6'd0, '0);
    step("cold2_8",  b(0) | b(8), 1'b0, 6'd0, 1'b1, 6'd8, b(0));

    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
